// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALU codes,
// opcode/funct constants and datapath mux selects.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_REX    = 4'd6,
        ST_RWB    = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JMP    = 4'd9,
        ST_JR     = 4'd10
    } state_e;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // States that talk to memory and therefore run the wait counter.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// R-type funct to ALU operation decode; valid_o flags a funct the REX path accepts.
module alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       valid_o
);

    always_comb begin
        alu_op_o = ALU_NONE;
        valid_o  = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_ADDU: alu_op_o = ALU_ADDU;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_SUBU: alu_op_o = ALU_SUBU;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_SLL:  alu_op_o = ALU_SLL;
            FN_SRL:  alu_op_o = ALU_SRL;
            FN_SRA:  alu_op_o = ALU_SRA;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with a bounded memory-wait counter.
// Outputs decode the current state; FETCH write strobes and the error pulses also see the inputs.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic       Timeout
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_sw_q;
    logic [3:0]         rex_op_q;

    logic [3:0]         rex_op;
    logic               rex_valid;
    logic               mem_timeout;
    logic               decode_illegal;

    alu_decode u_alu_decode (
        .funct_i  (funct),
        .alu_op_o (rex_op),
        .valid_o  (rex_valid)
    );

    always_comb begin
        mem_timeout = is_mem_state(state_q) && !mem_ready &&
                      (cnt_q == CNT_W'(MEM_TIMEOUT));

        decode_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_J: decode_illegal = 1'b0;
            OP_RTYPE: decode_illegal = (funct != FN_JR) && !rex_valid;
            default:  decode_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A FETCH timeout re-enters FETCH; the counter clear below handles it.
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_J:         state_d = ST_JMP;
                    OP_RTYPE: begin
                        if (funct == FN_JR)  state_d = ST_JR;
                        else if (rex_valid)  state_d = ST_REX;
                        else                 state_d = ST_FETCH;
                    end
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = is_sw_q ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready)        state_d = ST_MEMWB;
                else if (mem_timeout) state_d = ST_FETCH;
            end
            ST_MEMWR:  if (mem_ready || mem_timeout) state_d = ST_FETCH;
            ST_REX:    state_d = ST_RWB;
            default:   state_d = ST_FETCH;
        endcase

        // Only memory states ever hold, so any change or timeout means a fresh wait.
        if ((state_d != state_q) || mem_timeout) cnt_d = '0;
        else                                     cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_DECODE) is_sw_q <= (opcode == OP_SW);
        end
        if (state_q == ST_REX) rex_op_q <= rex_op;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALU_NONE;
        PCSource    = PCSRC_ALU;
        Illegal     = 1'b0;
        Timeout     = 1'b0;

        // Reset presents a quiet FETCH regardless of where the state register sits.
        if (reset) begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            ALUOp   = ALU_ADD;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    Timeout = mem_timeout;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_IMM_S2;
                    ALUOp   = ALU_ADD;
                    Illegal = decode_illegal;
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_ADD;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    Timeout = mem_timeout;
                end
                ST_MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    Timeout  = mem_timeout;
                end
                ST_REX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = rex_op;
                end
                ST_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    ALUOp    = rex_op_q;
                end
                ST_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                ST_JMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                ST_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_RS;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level trace model, per-cycle compare, pinned literals.
module tb_multicycle_control;

    localparam int T = 4;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BQ = 6'b000100, JJ = 6'b000010, FJR = 6'b001000;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic [1:0] pcsrc;
        logic ill, tmo;
    } outv_t;

    typedef struct packed {
        logic rst;
        logic mr;
        logic [5:0] op;
        logic [5:0] fn;
        outv_t e;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic Illegal, Timeout;

    multicycle_control #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    cyc_t q[$];
    outv_t trace [0:8191];
    outv_t exp_v;
    int cur_idx = 0;
    bit chk_en = 1'b0;

    // ALU code an accepted R-type funct must produce; returns 0 for unaccepted functs.
    function automatic bit r_code(input logic [5:0] fn, output logic [3:0] code);
        code = 4'd0;
        case (fn)
            6'b100000: code = 4'd1;
            6'b100001: code = 4'd10;
            6'b100010: code = 4'd2;
            6'b100011: code = 4'd11;
            6'b100100: code = 4'd3;
            6'b100101: code = 4'd4;
            6'b100111: code = 4'd5;
            6'b101010: code = 4'd6;
            6'b000000: code = 4'd7;
            6'b000010: code = 4'd8;
            6'b000011: code = 4'd9;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic outv_t o_fetch();
        outv_t e = '0;
        e.mrd = 1'b1; e.srcb = 2'b01; e.aluop = 4'd1;
        return e;
    endfunction

    task automatic push(input bit rst, input bit mr, input logic [5:0] op, input logic [5:0] fn, input outv_t e);
        cyc_t c;
        c.rst = rst; c.mr = mr; c.op = op; c.fn = fn; c.e = e;
        q.push_back(c);
    endtask

    task automatic push_reset();
        push(1'b1, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), o_fetch());
    endtask

    // A memory wait: 'delay' idle cycles then ready, unless the wait count reaches T first.
    task automatic mem_phase(input bit is_fetch, input int delay, input logic [5:0] op,
                             input logic [5:0] fn, input outv_t base, output bit ok);
        outv_t e;
        ok = 1'b0;
        for (int k = 0; k <= T; k++) begin
            e = base;
            if (k == delay) begin
                if (is_fetch) begin e.irw = 1'b1; e.pcw = 1'b1; end
                push(1'b0, 1'b1, op, fn, e);
                ok = 1'b1;
                return;
            end
            if (k == T) begin
                e.tmo = 1'b1;
                push(1'b0, 1'b0, op, fn, e);
                return;
            end
            push(1'b0, 1'b0, op, fn, e);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int df, input int dm);
        outv_t e, b;
        bit ok, fv;
        logic [3:0] code;
        mem_phase(1'b1, df, op, fn, o_fetch(), ok);
        if (!ok) return;
        fv = r_code(fn, code);
        e = '0; e.srcb = 2'b11; e.aluop = 4'd1;
        if (!(op == LW || op == SW || op == BQ || op == JJ || (op == RT && (fv || fn == FJR)))) e.ill = 1'b1;
        push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
        if (e.ill) return;
        e = '0;
        if (op == LW || op == SW) begin
            e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 4'd1;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
            b = '0; b.iord = 1'b1;
            if (op == LW) b.mrd = 1'b1; else b.mwr = 1'b1;
            mem_phase(1'b0, dm, op, fn, b, ok);
            if (ok && op == LW) begin
                e = '0; e.rw = 1'b1; e.m2r = 1'b1;
                push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
            end
        end else if (op == BQ) begin
            e.srca = 1'b1; e.aluop = 4'd2; e.pcwc = 1'b1; e.pcsrc = 2'b01;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
        end else if (op == JJ) begin
            e.pcw = 1'b1; e.pcsrc = 2'b10;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
        end else if (fn == FJR) begin
            e.pcw = 1'b1; e.pcsrc = 2'b11;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
        end else begin
            e.srca = 1'b1; e.aluop = code;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
            e = '0; e.rw = 1'b1; e.rdst = 1'b1; e.aluop = code;
            push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
        end
    endtask

    task automatic lit(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            outv_t d;
            d.pcw = PCWrite; d.pcwc = PCWriteCond; d.iord = IorD; d.mrd = MemRead; d.mwr = MemWrite;
            d.irw = IRWrite; d.m2r = MemToReg; d.rdst = RegDst; d.rw = RegWrite; d.srca = ALUSrcA;
            d.srcb = ALUSrcB; d.aluop = ALUOp; d.pcsrc = PCSource; d.ill = Illegal; d.tmo = Timeout;
            if (cur_idx < 8192) trace[cur_idx] = d;
            tests++;
            if (d !== exp_v) begin
                fails++;
                $display("FAIL cycle %0d outputs: got %h, want %h (op=%b fn=%b rdy=%b rst=%b)",
                         cur_idx, d, exp_v, opcode, funct, mem_ready, reset);
            end
        end
    end

    initial begin
        int i_add, i_lw, i_ill, i_to, i_j, i_sw, i_beq, i_jr, n;
        logic [3:0] code;
        logic [5:0] op, fn;
        logic [5:0] legal_fn [11] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                      6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};

        push_reset(); push_reset();
        i_add = q.size(); gen_instr(RT, 6'b100000, 0, 0);
        i_lw  = q.size(); gen_instr(LW, 6'd0, 0, 3);
        i_ill = q.size(); gen_instr(6'b111111, 6'd0, 0, 0);
        i_to  = q.size(); gen_instr(JJ, 6'd0, 5, 0);
        i_j   = q.size(); gen_instr(JJ, 6'd0, 0, 0);
        i_sw  = q.size(); gen_instr(SW, 6'd0, 0, 5);
        while (q.size() > i_sw + 5) void'(q.pop_back());
        push_reset();
        i_beq = q.size(); gen_instr(BQ, 6'd0, 4, 0);
        i_jr  = q.size(); gen_instr(RT, FJR, 0, 0);

        for (int k = 0; k < 300; k++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0, 1: op = LW;
                2:    op = SW;
                3, 4: begin op = RT; fn = legal_fn[$urandom_range(0, 10)]; end
                5:    begin op = RT; fn = FJR; end
                6:    begin op = RT; while (r_code(fn, code) || fn == FJR) fn = 6'($urandom); end
                7:    op = BQ;
                8:    op = JJ;
                default: op = 6'($urandom);
            endcase
            n = q.size();
            gen_instr(op, fn, $urandom_range(0, 5), $urandom_range(0, 5));
            if ($urandom_range(0, 14) == 0) begin
                int cut = n + $urandom_range(0, q.size() - n - 1);
                while (q.size() > cut) void'(q.pop_back());
                push_reset();
            end
        end

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op; funct = q[i].fn;
            exp_v = q[i].e; cur_idx = i; chk_en = 1'b1;
        end
        @(posedge clk); #1;
        chk_en = 1'b0;

        lit("reset_memread", int'(trace[0].mrd), 1);
        lit("reset_irwrite", int'(trace[0].irw) + int'(trace[1].pcw), 0);
        lit("reset_alusrcb", int'(trace[1].srcb), 1);
        lit("add_rex_aluop", int'(trace[i_add + 2].aluop), 1);
        n = 0;
        for (int i = i_add; i < i_add + 4; i++) n += int'(trace[i].rw);
        lit("add_regwrite_cycles", n, 1);
        lit("add_rwb_regdst", int'(trace[i_add + 3].rw & trace[i_add + 3].rdst), 1);
        n = 0;
        for (int i = i_lw; i < i_lw + 8; i++) n += int'(trace[i].mrd & trace[i].iord);
        lit("lw_memrd_cycles", n, 4);
        lit("lw_memwb", int'(trace[i_lw + 7].rw & trace[i_lw + 7].m2r), 1);
        lit("lw_next_fetch", int'(trace[i_lw + 8].irw), 1);
        lit("illegal_pulse", int'(trace[i_ill + 1].ill), 1);
        lit("illegal_no_write", int'(trace[i_ill].mwr | trace[i_ill].rw | trace[i_ill + 1].mwr | trace[i_ill + 1].rw), 0);
        lit("timeout_early", int'(trace[i_to + 3].tmo), 0);
        lit("timeout_pulse", int'(trace[i_to + 4].tmo), 1);
        n = 0;
        for (int i = i_to; i <= i_to + 4; i++) n += int'(trace[i].irw);
        lit("timeout_no_irwrite", n, 0);
        lit("j_after_timeout", int'(trace[i_j + 2].pcw) * 4 + int'(trace[i_j + 2].pcsrc), 6);
        lit("sw_memwrite", int'(trace[i_sw + 3].mwr), 1);
        lit("reset_in_memwr", int'(trace[i_sw + 5].mwr), 0);
        lit("after_reset_fetch", int'(trace[i_beq].mrd) * 2 + int'(trace[i_beq].mwr), 2);
        lit("fetch_ready_at_limit", int'(trace[i_beq + 4].irw) * 2 + int'(trace[i_beq + 4].tmo), 2);
        lit("beq_cond_src", int'(trace[i_beq + 6].pcwc) * 4 + int'(trace[i_beq + 6].pcsrc), 5);
        lit("jr_fetch", int'(trace[i_jr].irw), 1);
        lit("jr_pcwrite_src", int'(trace[i_jr + 2].pcw) * 4 + int'(trace[i_jr + 2].pcsrc), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles a memory state waits for mem_ready before abort.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26], valid from the IR after FETCH.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-007 PCWrite  output  1  unconditional PC load.
REQ-008 PCWriteCond  output  1  PC load if ALU zero (BEQ).
REQ-009 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 MemRead, MemWrite  output  1 each  memory strobes.
REQ-011 IRWrite  output  1  instruction register load.
REQ-012 MemToReg, RegDst, RegWrite  output  1 each  writeback controls.
REQ-013 ALUSrcA  output  1 (0=PC, 1=rs); ALUSrcB  output  2 (00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2).
REQ-014 ALUOp  output  4  ALU code: 0000 none, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA, 1010 ADDU, 1011 SUBU.
REQ-015 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs (JR).
REQ-016 Illegal, Timeout  output  1 each  one-cycle error pulses.

Function
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, JMP, JR.
REQ-018 Outputs are a Moore function of state, except that ALUOp in REX decodes funct; unlisted outputs are 0 in every state.
REQ-019 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0001, PCSource=00.
REQ-020 FETCH: IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; the state then advances to DECODE, otherwise it holds.
REQ-021 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0001 (branch target into ALUOut); next state by opcode: 100011/101011 -> MEMADR, 000000 -> REX or JR (funct 001000), 000100 -> BEQ, 000010 -> JMP.
REQ-022 DECODE with any other opcode, or opcode 000000 with an unlisted funct: Illegal=1 for one cycle, next state FETCH, no register or memory write.
REQ-023 R-type funct accepted: 100000, 100001, 100010, 100011, 100100, 100101, 100111, 101010, 000000, 000010, 000011; ALUOp in REX follows the REQ-014 mapping.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0001; next state MEMRD for lw, MEMWR for sw.
REQ-025 MEMRD: MemRead=1, IorD=1; holds until mem_ready, then goes to MEMWB.
REQ-026 MEMWB: RegWrite=1, MemToReg=1, RegDst=0; next state FETCH.
REQ-027 MEMWR: MemWrite=1, IorD=1; holds until mem_ready, then goes to FETCH.
REQ-028 REX: ALUSrcA=1, ALUSrcB=00, then RWB. RWB: RegWrite=1, RegDst=1, MemToReg=0, ALUOp held; next state FETCH.
REQ-029 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=0010, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-030 JMP: PCWrite=1, PCSource=10. JR: PCWrite=1, PCSource=11. Both go to FETCH next.
REQ-031 Wait counter: cleared on entering any memory state (FETCH, MEMRD, MEMWR), incremented each cycle without mem_ready.
REQ-032 When the wait counter reaches MEM_TIMEOUT with mem_ready still 0: Timeout=1 for one cycle, no IRWrite/PCWrite/RegWrite, next state FETCH.
REQ-033 mem_ready arriving in the same cycle as the counter reaching MEM_TIMEOUT counts as completion; no Timeout pulse.
REQ-034 mem_ready is ignored in non-memory states.
REQ-035 Cycle counts with mem_ready=1 immediately: R-type 4, lw 5, sw 4, beq 3, j/jr 3.

Reset
REQ-036 reset=1 at a clock edge forces state FETCH, clears the wait counter and drives Illegal=Timeout=0; this overrides any transition, including one mid-instruction.
REQ-037 During and after reset, outputs are the FETCH values, with no PCWrite or IRWrite until mem_ready is seen.

Structure
REQ-038 State encodings, ALUOp codes, opcode/funct constants and ALUSrcB/PCSource encodings shall live in a shared package, also imported by the existing decoder and the ALU.
REQ-039 The REX funct-to-ALUOp decode shall be a sub-module alu_decode (pure combinational); the FSM and the counter stay in multicycle_control.

Verification
REQ-040 Reset then an ADD (op 000000, funct 100000) with mem_ready=1: states FETCH, DECODE, REX, RWB; ALUOp=0001 in REX; RegWrite=1 only in RWB.
REQ-041 lw (100011) with mem_ready delayed 3 cycles in MEMRD: MEMRD held 4 cycles; MEMWB asserts RegWrite and MemToReg; total 8 cycles.
REQ-042 opcode 111111: Illegal pulse in DECODE, return to FETCH, zero MemWrite/RegWrite cycles.
REQ-043 MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: Timeout pulse after 4 wait cycles, no IRWrite, then re-enters FETCH.
REQ-044 reset asserted during MEMWR: next cycle is FETCH, MemWrite=0, counter cleared.
REQ-045 beq then jr back-to-back: PCWriteCond=1 with PCSource=01 in BEQ; PCWrite=1 with PCSource=11 in JR; 3 cycles each.
